// File: rtl/syscall_unit.sv
// Syscall responder: print_int / print_char (plus print_hex with SYSCALL_HEX_EN) stream ASCII; exit halts.
// Latency: print_char acks on the byte transfer; print_int <=11 bytes + <=100 compute cycles; unsupported acks next cycle.
// Backpressure: char_data held while char_valid & ~char_ready; syscall_stall holds decode until ack.
`timescale 1ns/1ps
module syscall_unit #(
    parameter logic [31:0] FUNCT_PRINT_INT  = 32'd1,
    parameter logic [31:0] FUNCT_EXIT       = 32'd10,
`ifdef SYSCALL_HEX_EN
    parameter logic [31:0] FUNCT_PRINT_HEX  = 32'd34,
`endif
    parameter logic [31:0] FUNCT_PRINT_CHAR = 32'd11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param1,
    output logic        syscall_stall,
    output logic        syscall_ack,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        halted,
    output logic        bad_syscall
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIGN  = 3'd1,
        DIGIT = 3'd2,
        EMIT  = 3'd3,
`ifdef SYSCALL_HEX_EN
        HEX   = 3'd4,
`endif
        HALT  = 3'd5
    } stateType;

    stateType    state, stateNext, retState;
    logic [31:0] mag;
    logic [3:0]  idx;
    logic [3:0]  digit;
    logic        started;
    logic        lastByte;
    logic [7:0]  charReg;
    logic        ackBad;
    logic        haltedReg;
    logic        badReg;

    logic        accept, transfer, geq, emitDigit;
    logic        isInt, isChar, isExit, isHex;
    logic [31:0] powVal;

    function automatic logic [31:0] pow10(input logic [3:0] i);
        case (i)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd0;
        endcase
    endfunction

    assign isInt  = (syscall_funct == FUNCT_PRINT_INT);
    assign isChar = (syscall_funct == FUNCT_PRINT_CHAR);
    assign isExit = (syscall_funct == FUNCT_EXIT);
`ifdef SYSCALL_HEX_EN
    assign isHex  = (syscall_funct == FUNCT_PRINT_HEX);
`else
    assign isHex  = 1'b0;
`endif

    // ackBad blocks re-accepting the same request during its ack cycle
    assign accept    = (state == IDLE) & syscall_valid & ~ackBad;
    assign char_valid = (state == SIGN) | (state == EMIT);
    assign transfer  = char_valid & char_ready;
    assign powVal    = pow10(idx);
    assign geq       = (mag >= powVal);
    assign emitDigit = (digit != 4'd0) | started | (idx == 4'd0);

    assign syscall_ack   = ackBad | ((state == EMIT) & transfer & lastByte);
    assign syscall_stall = (syscall_valid & ~syscall_ack) | haltedReg;
    assign char_data     = charReg;
    assign halted        = haltedReg;
    assign bad_syscall   = badReg;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (isChar)      stateNext = EMIT;
                    else if (isInt)  stateNext = syscall_param1[31] ? SIGN : DIGIT;
                    else if (isExit) stateNext = HALT;
`ifdef SYSCALL_HEX_EN
                    else if (isHex)  stateNext = HEX;
`endif
                    else             stateNext = IDLE;
                end
            end
            SIGN:  if (transfer) stateNext = DIGIT;
            DIGIT: if (!geq && emitDigit) stateNext = EMIT;
            EMIT:  if (transfer) stateNext = lastByte ? IDLE : retState;
`ifdef SYSCALL_HEX_EN
            HEX:   stateNext = EMIT;
`endif
            HALT:  stateNext = HALT;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            retState  <= IDLE;
            mag       <= 32'd0;
            idx       <= 4'd0;
            digit     <= 4'd0;
            started   <= 1'b0;
            lastByte  <= 1'b0;
            charReg   <= 8'd0;
            ackBad    <= 1'b0;
            haltedReg <= 1'b0;
            badReg    <= 1'b0;
        end else begin
            state  <= stateNext;
            ackBad <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isChar) begin
                            charReg  <= syscall_param1[7:0];
                            lastByte <= 1'b1;
                        end else if (isInt) begin
                            // two's-complement negate maps 0x80000000 onto 2147483648
                            mag      <= syscall_param1[31] ? (32'd0 - syscall_param1) : syscall_param1;
                            idx      <= 4'd9;
                            digit    <= 4'd0;
                            started  <= 1'b0;
                            lastByte <= 1'b0;
                            retState <= DIGIT;
                            if (syscall_param1[31]) charReg <= 8'h2D;
                        end else if (isExit) begin
                            haltedReg <= 1'b1;
                        end else if (isHex) begin
`ifdef SYSCALL_HEX_EN
                            mag      <= syscall_param1;
                            idx      <= 4'd0;
                            lastByte <= 1'b0;
                            retState <= HEX;
`endif
                        end else begin
                            badReg <= 1'b1;
                            ackBad <= 1'b1;
                        end
                    end
                end
                DIGIT: begin
                    if (geq) begin
                        mag   <= mag - powVal;
                        digit <= digit + 4'd1;
                    end else begin
                        if (emitDigit) begin
                            charReg  <= 8'h30 + {4'd0, digit};
                            started  <= 1'b1;
                            lastByte <= (idx == 4'd0);
                        end
                        idx   <= idx - 4'd1;
                        digit <= 4'd0;
                    end
                end
`ifdef SYSCALL_HEX_EN
                HEX: begin
                    if (idx == 4'd0) begin
                        charReg <= 8'h30;
                    end else if (idx == 4'd1) begin
                        charReg <= 8'h78;
                    end else begin
                        charReg <= (mag[31:28] < 4'd10) ? (8'h30 + {4'd0, mag[31:28]})
                                                         : (8'h57 + {4'd0, mag[31:28]});
                        mag     <= {mag[27:0], 4'd0};
                    end
                    lastByte <= (idx == 4'd9);
                    idx      <= idx + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
